// File: rtl/hdmi_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper
// for the HDMI source switch.
package hdmi_pkg;

   typedef enum logic [2:0] {
      ST_PLLRST     = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_RUN        = 3'd2,
      ST_WAIT_VSYNC = 3'd3,
      ST_SWITCH     = 3'd4
   } hdmi_state_e;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_VSYNC_TIMEOUT = 1048576;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 1048576;
   localparam int unsigned DEF_SYNC_STAGES   = 2;

   // Counter width for a terminal count of n; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level signal.
module sync_ff
   import hdmi_pkg::*;
#(
   parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/hdmi_source_switch.sv
// Selects one of two HDMI receivers for the transmitter, switching on a frame
// boundary (manual) or immediately (failover) and re-locking the TX PLL after.
module hdmi_source_switch
   import hdmi_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned VSYNC_TIMEOUT = DEF_VSYNC_TIMEOUT,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        src_req,
   input  logic        auto_en,
   input  logic        rdy0,
   input  logic        rdy1,
   input  logic        vsync0,
   input  logic        vsync1,
   input  logic        tx_plllckd,
   output logic        src_sel,
   output logic        tx_pll_reset,
   output logic        switching,
   output logic        lock_err,
   output hdmi_state_e state_dbg
);

   localparam int unsigned RST_W = cnt_width(RST_CYCLES);
   localparam int unsigned VS_W  = cnt_width(VSYNC_TIMEOUT);
   localparam int unsigned LK_W  = cnt_width(LOCK_TIMEOUT);

   hdmi_state_e       state;
   logic [RST_W-1:0]  rst_cnt;
   logic [VS_W-1:0]   vs_cnt;
   logic [LK_W-1:0]   lk_cnt;
   logic              vs_prev;

   logic rdy0_s, rdy1_s, vsync0_s, vsync1_s, lock_s;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy0   (.clk(pclk), .rst(rst), .d(rdy0),       .q(rdy0_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy1   (.clk(pclk), .rst(rst), .d(rdy1),       .q(rdy1_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_vsync0 (.clk(pclk), .rst(rst), .d(vsync0),     .q(vsync0_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_vsync1 (.clk(pclk), .rst(rst), .d(vsync1),     .q(vsync1_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock   (.clk(pclk), .rst(rst), .d(tx_plllckd), .q(lock_s));

   // "cur" is the source feeding the TX now, "tgt" is the other one.
   logic cur_rdy, tgt_rdy, cur_vs, vs_rise;
   logic failover, manual, abort;
   logic rst_done, vs_done, lk_done;

   assign cur_rdy  = src_sel ? rdy1_s   : rdy0_s;
   assign tgt_rdy  = src_sel ? rdy0_s   : rdy1_s;
   assign cur_vs   = src_sel ? vsync1_s : vsync0_s;
   assign vs_rise  = cur_vs & ~vs_prev;

   assign failover = auto_en & ~cur_rdy & tgt_rdy;
   assign manual   = (src_req != src_sel) & tgt_rdy;
   assign abort    = ~tgt_rdy | (src_req == src_sel);

   assign rst_done = (rst_cnt == RST_W'(RST_CYCLES - 1));
   assign vs_done  = (vs_cnt  == VS_W'(VSYNC_TIMEOUT - 1));
   assign lk_done  = (lk_cnt  == LK_W'(LOCK_TIMEOUT - 1));

   assign state_dbg = state;

   // Outputs are registered alongside the state so they change on the same
   // edge as the state they belong to; each counter is cleared on entry.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state        <= ST_PLLRST;
         src_sel      <= 1'b0;
         tx_pll_reset <= 1'b1;
         switching    <= 1'b1;
         lock_err     <= 1'b0;
         rst_cnt      <= '0;
         vs_cnt       <= '0;
         lk_cnt       <= '0;
         vs_prev      <= 1'b0;
      end else begin
         vs_prev <= cur_vs;
         case (state)
            ST_PLLRST: begin
               if (rst_done) begin
                  state        <= ST_WAIT_LOCK;
                  tx_pll_reset <= 1'b0;
                  lk_cnt       <= '0;
               end else if (rst_cnt != {RST_W{1'b1}}) begin
                  rst_cnt <= rst_cnt + RST_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state     <= ST_RUN;
                  switching <= 1'b0;
                  lock_err  <= 1'b0;
               end else if (lk_done) begin
                  state        <= ST_PLLRST;
                  tx_pll_reset <= 1'b1;
                  lock_err     <= 1'b1;
                  rst_cnt      <= '0;
               end else if (lk_cnt != {LK_W{1'b1}}) begin
                  lk_cnt <= lk_cnt + LK_W'(1);
               end
            end
            ST_RUN: begin
               // Failover is checked first so it wins over a manual request.
               if (failover) begin
                  state        <= ST_SWITCH;
                  tx_pll_reset <= 1'b1;
                  switching    <= 1'b1;
               end else if (manual) begin
                  state     <= ST_WAIT_VSYNC;
                  switching <= 1'b1;
                  vs_cnt    <= '0;
               end
            end
            ST_WAIT_VSYNC: begin
               if (abort) begin
                  state     <= ST_RUN;
                  switching <= 1'b0;
               end else if (vs_rise || vs_done) begin
                  state        <= ST_SWITCH;
                  tx_pll_reset <= 1'b1;
               end else if (vs_cnt != {VS_W{1'b1}}) begin
                  vs_cnt <= vs_cnt + VS_W'(1);
               end
            end
            ST_SWITCH: begin
               src_sel <= ~src_sel;
               state   <= ST_PLLRST;
               rst_cnt <= '0;
            end
            default: begin
               state        <= ST_PLLRST;
               tx_pll_reset <= 1'b1;
               switching    <= 1'b1;
               rst_cnt      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hdmi_source_switch.sv
// Bench for hdmi_source_switch: directed scenarios plus a random soak, all
// compared cycle by cycle against a behavioural model of the switch rules.
module tb_hdmi_source_switch;
   import hdmi_pkg::*;

   localparam int unsigned RST_CYCLES    = 4;
   localparam int unsigned VSYNC_TIMEOUT = 64;
   localparam int unsigned LOCK_TIMEOUT  = 64;
   localparam int unsigned SYNC_STAGES   = 2;

   // ---------------- clock / reset ----------------
   logic pclk = 1'b0;
   logic rst  = 1'b1;
   always #5 pclk = ~pclk;

   logic src_req = 1'b0, auto_en = 1'b0;
   logic rdy0 = 1'b0, rdy1 = 1'b0, vsync0 = 1'b0, vsync1 = 1'b0, tx_plllckd = 1'b0;
   logic src_sel, tx_pll_reset, switching, lock_err;
   hdmi_state_e state_dbg;

   hdmi_source_switch #(
      .RST_CYCLES(RST_CYCLES), .VSYNC_TIMEOUT(VSYNC_TIMEOUT),
      .LOCK_TIMEOUT(LOCK_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .pclk(pclk), .rst(rst), .src_req(src_req), .auto_en(auto_en),
      .rdy0(rdy0), .rdy1(rdy1), .vsync0(vsync0), .vsync1(vsync1),
      .tx_plllckd(tx_plllckd), .src_sel(src_sel), .tx_pll_reset(tx_pll_reset),
      .switching(switching), .lock_err(lock_err), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Synchronized inputs are the raw inputs delayed by SYNC_STAGES edges.
   logic [4:0]  raw_q[$];
   logic [4:0]  s_prev;
   hdmi_state_e m_state;
   logic        m_sel, m_err;
   int          m_left;

   task automatic enter(input hdmi_state_e st);
      m_state = st;
      case (st)
         ST_PLLRST:     m_left = RST_CYCLES;
         ST_WAIT_LOCK:  m_left = LOCK_TIMEOUT;
         ST_WAIT_VSYNC: m_left = VSYNC_TIMEOUT;
         default:       m_left = 0;
      endcase
   endtask

   task automatic model_reset();
      raw_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) raw_q.push_back(5'b0);
      s_prev = 5'b0;
      m_sel  = 1'b0;
      m_err  = 1'b0;
      enter(ST_PLLRST);
   endtask

   task automatic model_step();
      logic [4:0] s;
      logic rdy_cur, rdy_tgt, vs_rise, lock;
      raw_q.push_back({tx_plllckd, vsync1, vsync0, rdy1, rdy0});
      s       = raw_q.pop_front();
      rdy_cur = m_sel ? s[1] : s[0];
      rdy_tgt = m_sel ? s[0] : s[1];
      vs_rise = m_sel ? (s[3] & ~s_prev[3]) : (s[2] & ~s_prev[2]);
      lock    = s[4];
      case (m_state)
         ST_PLLRST: begin
            m_left--;
            if (m_left == 0) enter(ST_WAIT_LOCK);
         end
         ST_WAIT_LOCK: begin
            if (lock) begin
               m_err = 1'b0;
               enter(ST_RUN);
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_err = 1'b1;
                  enter(ST_PLLRST);
               end
            end
         end
         ST_RUN: begin
            if (auto_en && !rdy_cur && rdy_tgt) enter(ST_SWITCH);
            else if ((src_req != m_sel) && rdy_tgt) enter(ST_WAIT_VSYNC);
         end
         ST_WAIT_VSYNC: begin
            if (!rdy_tgt || (src_req == m_sel)) enter(ST_RUN);
            else if (vs_rise) enter(ST_SWITCH);
            else begin
               m_left--;
               if (m_left == 0) enter(ST_SWITCH);
            end
         end
         ST_SWITCH: begin
            m_sel = !m_sel;
            enter(ST_PLLRST);
         end
         default: enter(ST_PLLRST);
      endcase
      s_prev = s;
   endtask

   // ---------------- PLL behaviour / driver tasks ----------------
   logic pll_dead   = 1'b0;
   int   lock_delay = 6;
   int   lock_wait  = 0;

   task automatic pll_drive();
      if (tx_pll_reset) begin
         lock_wait  = lock_delay;
         tx_plllckd = 1'b0;
      end else if (pll_dead) begin
         tx_plllckd = 1'b0;
      end else if (lock_wait > 0) begin
         lock_wait--;
      end else begin
         tx_plllckd = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      if (!rst) model_step();
      @(negedge pclk);
      check("src_sel",   32'(src_sel),      32'(m_sel));
      check("pll_reset", 32'(tx_pll_reset), 32'(m_state == ST_PLLRST || m_state == ST_SWITCH));
      check("switching", 32'(switching),    32'(m_state != ST_RUN));
      check("lock_err",  32'(lock_err),     32'(m_err));
      check("state",     32'(state_dbg),    32'(m_state));
      pll_drive();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      model_reset();
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic wait_state(input string tag, input hdmi_state_e st, input int max, output int n);
      n = 0;
      while (state_dbg != st && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(state_dbg), 32'(st));
   endtask

   task automatic count_pll_pulse(output int n);
      n = 0;
      while (tx_pll_reset && n < 200) begin
         tick();
         n++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      model_reset();

      // Reset release, lock ~10 cycles later.
      do_reset(3);
      count_pll_pulse(n);
      check("rst_pulse_len", n, RST_CYCLES);
      wait_state("reach_run", ST_RUN, 100, n);
      check("run_src_sel", 32'(src_sel), 0);
      check("run_switching", 32'(switching), 0);

      // Manual switch on a vsync0 rising edge.
      rdy0 = 1'b1; rdy1 = 1'b1; src_req = 1'b1;
      wait_state("enter_wait_vsync", ST_WAIT_VSYNC, 20, n);
      repeat (20) tick();
      vsync0 = 1'b1;
      wait_state("vsync_switch", ST_SWITCH, 20, n);
      check("vsync_to_switch_le", 32'(n <= SYNC_STAGES + 1), 1);
      count_pll_pulse(n);
      check("switch_pulse_len", n, RST_CYCLES + 1);
      check("manual_src_sel", 32'(src_sel), 1);
      wait_state("manual_back_run", ST_RUN, 100, n);
      vsync0 = 1'b0;

      // Manual switch back with vsync1 stuck low: vsync timeout.
      src_req = 1'b0;
      wait_state("timeout_wait_vsync", ST_WAIT_VSYNC, 20, n);
      wait_state("timeout_switch", ST_SWITCH, 200, n);
      check("vsync_timeout_len", n, VSYNC_TIMEOUT);
      wait_state("timeout_back_run", ST_RUN, 100, n);
      check("timeout_src_sel", 32'(src_sel), 0);

      // Failover from rx0 to rx1 with no vsync wait.
      auto_en = 1'b1;
      rdy0    = 1'b0;
      wait_state("failover_switch", ST_SWITCH, 20, n);
      check("failover_fast", 32'(n <= SYNC_STAGES + 1), 1);
      wait_state("failover_run", ST_RUN, 100, n);
      check("failover_src_sel", 32'(src_sel), 1);
      src_req = 1'b1; rdy0 = 1'b1; auto_en = 1'b0;

      // PLL never locks: lock_err after the lock timeout, then recovery.
      src_req  = 1'b0;
      pll_dead = 1'b1;
      do_reset(3);
      n = 0;
      while (!lock_err && n < 300) begin
         tick();
         n++;
      end
      check("lock_err_time", n, RST_CYCLES + LOCK_TIMEOUT);
      check("lock_err_retry", 32'(state_dbg), 32'(ST_PLLRST));
      repeat (10) tick();
      pll_dead   = 1'b0;
      lock_delay = 3;
      wait_state("lock_recover_run", ST_RUN, 200, n);
      check("lock_err_clear", 32'(lock_err), 0);

      // Random soak.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) rdy0 = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 3) rdy1 = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 10) vsync0 = ~vsync0;
         if ($urandom_range(0, 99) < 10) vsync1 = ~vsync1;
         if ($urandom_range(0, 99) < 2) src_req = ~src_req;
         if ($urandom_range(0, 99) < 1) auto_en = ~auto_en;
         if ($urandom_range(0, 99) < 2) lock_delay = $urandom_range(0, 12);
         tick();
      end

      // Asynchronous reset in the middle of a pending switch.
      rdy0 = 1'b1; rdy1 = 1'b1; auto_en = 1'b0; vsync0 = 1'b0; vsync1 = 1'b0;
      wait_state("pre_arst_run", ST_RUN, 300, n);
      src_req = ~src_sel;
      wait_state("pre_arst_wait_vsync", ST_WAIT_VSYNC, 20, n);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("arst_src_sel",   32'(src_sel),      0);
      check("arst_pll_reset", 32'(tx_pll_reset), 1);
      check("arst_switching", 32'(switching),    1);
      check("arst_lock_err",  32'(lock_err),     0);
      check("arst_state",     32'(state_dbg),    32'(ST_PLLRST));
      repeat (3) tick();
      rst = 1'b0;
      wait_state("post_arst_run", ST_RUN, 100, n);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
